seg_scan_ctrl: RTL
==================

# seg_scan_ctrl

Time-multiplexed scan controller that shares one registered `decoder_7_seg` among `NUM_DIGITS` common-anode digits. It sequences digit selection, applies an inter-digit blanking gap against ghosting, and double-buffers the displayed value so it updates only at frame boundaries. It sits between the counter/BCD logic and the board's segment and anode pins.

## Interface
- `NUM_DIGITS`, 4: number of digits scanned, range 2–8.
- `PRESCALE`, 50000: `CLK` cycles each digit is lit (SHOW), ≥1.
- `BLANK_CYCLES`, 16: `CLK` cycles all anodes are off before each digit (BLANK), ≥1.
- `CLK` in 1: system clock, rising edge.
- `RST` in 1: reset, asynchronous, active-high.
- `LOAD` in 1: single-cycle strobe; captures `VALUE`.
- `VALUE` in 4*NUM_DIGITS: BCD digits; digit k = `VALUE[4k+3:4k]`; digit 0 is the rightmost.
- `SEG` out 8: active-low segments {a..g, dp}, driven by the internal decoder.
- `AN` out NUM_DIGITS: active-low anode enables; at most one bit low.
- `BUSY` out 1: a captured value is pending, not yet displayed.
- `FRAME_DONE` out 1: one-cycle pulse in the last SHOW cycle of digit NUM_DIGITS-1.

## Operation
- Registers: `active` (displayed), `pending`, `pend_flag`, `idx` (0..NUM_DIGITS-1), `state` {BLANK, SHOW}, `cnt`.
- Reset values: `AN` all 1, `BUSY` 0, `FRAME_DONE` 0, `active` all 4'hF, `idx` 0, `state` BLANK, `cnt` 0.
- Decoder input `D` = `active` nibble `idx` (combinational). Nibbles 10–15 pass through; the decoder blanks them (SEG 8'hFF).
- BLANK: `AN` all 1. `cnt` counts 0..BLANK_CYCLES-1, then the block moves to SHOW with `cnt` 0.
- SHOW: `AN[idx]` = 0. `cnt` counts 0..PRESCALE-1, then the block moves to BLANK with `idx` = (idx+1) mod NUM_DIGITS. Wrap from NUM_DIGITS-1 to 0 is the frame boundary.
- LOAD handling:
  - `LOAD` writes `pending` from `VALUE` and sets `pend_flag`.
  - A second `LOAD` before the boundary overwrites `pending` (latest wins).
- At the frame boundary edge with `pend_flag` set: `active` ← `pending`, then `pend_flag` is cleared.
- `LOAD` in the boundary cycle (`FRAME_DONE`=1): `VALUE` is written directly to `active`. `pend_flag` is cleared and `BUSY` stays 0.
- `BUSY` = `pend_flag`.

## Timing
- Frame length = NUM_DIGITS × (BLANK_CYCLES + PRESCALE) cycles.
- `SEG` lags `D` by one cycle (decoder register). `D` changes only at BLANK entry, and BLANK_CYCLES ≥ 1, so `SEG` is always valid for the whole SHOW window.
- `AN` is registered and changes on the same edge as the state transition.
- A `LOAD` at cycle t is displayed starting with digit 0 of the next frame. Worst-case latency is one frame plus BLANK_CYCLES.
- An `RST` assertion mid-operation forces `AN` all 1 and clears `BUSY`/`FRAME_DONE` immediately, without waiting for `CLK`. `SEG` goes to 8'hFF on the first `CLK` edge, because `active` resets to 4'hF.

## Configuration
- `SEG_SCAN_LZB_EN` defined:
  - Leading-zero blanking is enabled.
  - Every digit above the most significant nonzero digit of `active` presents 4'hF to the decoder.
  - Digit 0 always shows, so an all-zero value shows a single "0".
- Undefined: all digits are shown exactly as stored.

## Structure
- The shared package holds the active-low segment constant for blank (8'hFF), the blank nibble code 4'hF, and the `state` encoding.
- One sub-module is used: the existing `decoder_7_seg` (registered, active-low, blanks codes ≥10). The scan FSM, counters and buffering stay in this module.

## Test plan
All scenarios use NUM_DIGITS=4, PRESCALE=4, BLANK_CYCLES=2 (24-cycle frame).
- Reset: assert `RST` → `AN`=4'b1111, `BUSY`=0, `FRAME_DONE`=0; after the first `CLK`, `SEG`=8'hFF.
- Basic load: `LOAD` `VALUE`=16'h1234 mid-frame → `BUSY`=1 until the boundary. The next frame shows:
  - `AN`=1110 with `SEG`=8'b10011001 (digit 0, "4")
  - `AN`=0111 with `SEG`=8'b10011111 (digit 3, "1")
  - `FRAME_DONE` every 24 cycles.
- Overwrite: `LOAD` 16'h1111, then `LOAD` 16'h9876 in the same frame → no frame ever shows 1; digit 0 `SEG`=8'b01000001.
- Boundary bypass: `LOAD` 16'h0005 in the `FRAME_DONE` cycle → `BUSY` stays 0; digit 0 of the immediately following slot shows `SEG`=8'b01001001.
- Blanking and LZB, `VALUE`=16'h0040:
  - with `SEG_SCAN_LZB_EN`: digits 3 and 2 show `SEG`=8'hFF, digit 1 shows 8'b10011001, digit 0 shows 8'b00000011.
  - without it: digits 3 and 2 show 8'b00000011.
  - in both cases `AN` is all 1 for 2 cycles before each digit.
- Reset mid-SHOW: `RST` while `AN`=1101 → `AN`=1111 in the same cycle. After release, scanning restarts from BLANK with digit 0 and all digits blank.

Source files
------------

// File: rtl/seg_scan_ctrl_pkg.sv
// Shared definitions for the multiplexed seven-segment scan controller.
// Leading-zero blanking is built in when SEG_SCAN_LZB_EN is defined.
package seg_scan_ctrl_pkg;

  localparam logic [7:0] SEG_OFF   = 8'hFF;
  localparam logic [3:0] NIB_BLANK = 4'hF;

  typedef enum logic {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } state_t;

endpackage

// File: rtl/seg_scan_ctrl_decoder.sv
// Registered BCD to seven-segment decoder, active-low {a..g, dp}.
// Codes 10..15 produce a dark digit.
module decoder_7_seg
  import seg_scan_ctrl_pkg::*;
(
  input  logic       CLK,
  input  logic [3:0] D,
  output logic [7:0] SEG
);

  always_ff @(posedge CLK) begin
    case (D)
      4'd0:    SEG <= 8'b00000011;
      4'd1:    SEG <= 8'b10011111;
      4'd2:    SEG <= 8'b00100101;
      4'd3:    SEG <= 8'b00001101;
      4'd4:    SEG <= 8'b10011001;
      4'd5:    SEG <= 8'b01001001;
      4'd6:    SEG <= 8'b01000001;
      4'd7:    SEG <= 8'b00011111;
      4'd8:    SEG <= 8'b00000001;
      4'd9:    SEG <= 8'b00001001;
      default: SEG <= SEG_OFF;
    endcase
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed common-anode digit scanner with frame-synchronous update.
// Define SEG_SCAN_LZB_EN to blank leading zeros.
module seg_scan_ctrl
  import seg_scan_ctrl_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int PRESCALE     = 50000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    LOAD,
  input  logic [4*NUM_DIGITS-1:0] VALUE,
  output logic [7:0]              SEG,
  output logic [NUM_DIGITS-1:0]   AN,
  output logic                    BUSY,
  output logic                    FRAME_DONE
);

  localparam int IW   = $clog2(NUM_DIGITS);
  localparam int MAXC = (PRESCALE > BLANK_CYCLES) ?
                        PRESCALE : BLANK_CYCLES;
  localparam int CW   = $clog2(MAXC) + 1;

  localparam logic [IW-1:0] LAST  = IW'(NUM_DIGITS - 1);
  localparam logic [CW-1:0] P_END = CW'(PRESCALE - 1);
  localparam logic [CW-1:0] B_END = CW'(BLANK_CYCLES - 1);

  state_t                  state, state_n;
  logic [IW-1:0]           idx, idx_n;
  logic [CW-1:0]           cnt, cnt_n;
  logic [NUM_DIGITS-1:0]   an_n;
  logic                    fd_n;
  logic [4*NUM_DIGITS-1:0] active, pending;
  logic                    pend_flag;
  logic [3:0]              d;

  always_comb begin
    state_n = state;
    idx_n   = idx;
    cnt_n   = cnt + CW'(1);
    unique case (state)
      BLANK: if (cnt == B_END) begin
        state_n = SHOW;
        cnt_n   = '0;
      end
      SHOW: if (cnt == P_END) begin
        state_n = BLANK;
        cnt_n   = '0;
        idx_n   = (idx == LAST) ? '0 : idx + IW'(1);
      end
    endcase
    an_n = '1;
    if (state_n == SHOW)
      an_n[idx_n] = 1'b0;
    fd_n = (state_n == SHOW) && (idx_n == LAST) &&
           (cnt_n == P_END);
  end

  // FRAME_DONE high marks the cycle whose closing edge is the frame boundary
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= BLANK;
      idx        <= '0;
      cnt        <= '0;
      AN         <= '1;
      FRAME_DONE <= 1'b0;
      active     <= {NUM_DIGITS{NIB_BLANK}};
      pending    <= {NUM_DIGITS{NIB_BLANK}};
      pend_flag  <= 1'b0;
    end else begin
      state      <= state_n;
      idx        <= idx_n;
      cnt        <= cnt_n;
      AN         <= an_n;
      FRAME_DONE <= fd_n;
      if (FRAME_DONE) begin
        if (LOAD)
          active <= VALUE;
        else if (pend_flag)
          active <= pending;
        pend_flag <= 1'b0;
      end else if (LOAD) begin
        pending   <= VALUE;
        pend_flag <= 1'b1;
      end
    end
  end

  assign BUSY = pend_flag;

`ifdef SEG_SCAN_LZB_EN
  logic [IW-1:0] msd;

  always_comb begin
    msd = '0;
    for (int k = 1; k < NUM_DIGITS; k++)
      if (active[4*k +: 4] != 4'h0)
        msd = IW'(k);
  end

  assign d = (idx > msd) ? NIB_BLANK : active[4*idx +: 4];
`else
  assign d = active[4*idx +: 4];
`endif

  decoder_7_seg u_dec (
    .CLK (CLK),
    .D   (d),
    .SEG (SEG)
  );

endmodule
